// File: rtl/joypad_poller_pkg.sv
// Shared definitions for the joypad poller: button bit positions, FSM state codes
// and the raw-to-active-high sample conversion.
package joypad_poller_pkg;

  // Bit positions follow the nes_bridge shift order.
  typedef enum int {
    BTN_A      = 0,
    BTN_B      = 1,
    BTN_SELECT = 2,
    BTN_START  = 3,
    BTN_UP     = 4,
    BTN_DOWN   = 5,
    BTN_LEFT   = 6,
    BTN_RIGHT  = 7
  } btn_idx_t;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_PROC = 2'd3
  } poll_state_t;

  function automatic logic [7:0] to_active_high(input logic [7:0] raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/joypad_poller_button_debounce.sv
// Per-bit debounce: a bit only changes after DEBOUNCE consecutive differing samples;
// emits registered pressed/released masks alongside each update.
module button_debounce #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    next_cnt [WIDTH];
  logic [WIDTH-1:0] next_buttons;

  // A matching sample clears the run; the counter saturates at the switch point.
  always_comb begin
    next_buttons = buttons;
    next_cnt     = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (sample[i] == buttons[i]) begin
        next_cnt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        next_buttons[i] = sample[i];
        next_cnt[i]     = '0;
      end else begin
        next_cnt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      pressed  <= '0;
      released <= '0;
      if (sample_en) begin
        buttons  <= next_buttons;
        cnt      <= next_cnt;
        pressed  <= next_buttons & ~buttons;
        released <= ~next_buttons & buttons;
      end
    end
  end

endmodule

// File: rtl/joypad_poller.sv
// Periodic nes_bridge poller: requests a joypad read every POLL_PERIOD idle cycles,
// guards each transaction with a timeout and feeds completed samples to the debouncer.
module joypad_poller
  import joypad_poller_pkg::*;
#(
  parameter int POLL_PERIOD = 833_333,
  parameter int TIMEOUT     = 2_000_000,
  parameter int DEBOUNCE    = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       bridge_start,
  input  logic       bridge_ready,
  input  logic [7:0] bridge_joypad,
  input  logic       bridge_joypad_valid,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic       update,
  output logic       timeout_err
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

  poll_state_t state, next_state;
  logic [PW-1:0] period_ctr;
  logic [TW-1:0] tmo_ctr;
  logic [7:0]    sample;
  logic          sample_en;
  logic          busy_live;
  logic          completion;
  logic          abandon;
  logic          expired;

  // The first busy cycle is ignored: ready may not have dropped yet.
  assign busy_live  = (state == S_BUSY) && (tmo_ctr != '0);
  assign completion = busy_live && bridge_ready && bridge_joypad_valid;
  assign abandon    = busy_live && bridge_ready && !bridge_joypad_valid;
  assign expired    = (state == S_BUSY) && (tmo_ctr == TMO_LAST) && !completion;

  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WAIT: if (enable && period_ctr == PERIOD_LAST) next_state = S_REQ;
      S_REQ:  if (bridge_ready) next_state = S_BUSY;
      S_BUSY: begin
        if (completion)           next_state = S_PROC;
        else if (abandon || expired) next_state = S_WAIT;
      end
      S_PROC: next_state = S_WAIT;
      default: next_state = S_WAIT;
    endcase
  end

  always_comb begin
    bridge_start = (state == S_REQ) && bridge_ready && !rst;
    sample_en    = (state == S_PROC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_ctr <= '0;
      tmo_ctr    <= '0;
    end else begin
      if (state == S_WAIT && enable)
        period_ctr <= (period_ctr == PERIOD_LAST) ? '0 : period_ctr + PW'(1);
      else
        period_ctr <= '0;
      if (state == S_REQ)
        tmo_ctr <= '0;
      else if (state == S_BUSY && tmo_ctr != TMO_LAST)
        tmo_ctr <= tmo_ctr + TW'(1);
    end
  end

  // A good poll clears a previous timeout; a failed one never touches the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample      <= '0;
      timeout_err <= 1'b0;
      update      <= 1'b0;
    end else begin
      update <= sample_en;
      if (completion) begin
        sample      <= to_active_high(bridge_joypad, ACTIVE_LOW != 0);
        timeout_err <= 1'b0;
      end else if (abandon || expired) begin
        timeout_err <= 1'b1;
      end
    end
  end

  button_debounce #(
    .WIDTH    (8),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .sample    (sample),
    .buttons   (buttons),
    .pressed   (pressed),
    .released  (released)
  );

endmodule

// File: tb/tb_joypad_poller.sv
// Scoreboard bench for joypad_poller: a behavioural nes_bridge serves queued raw
// samples while a negedge monitor checks every update against expected results.
module tb_joypad_poller;

  localparam int POLL_PERIOD = 16;
  localparam int TIMEOUT     = 64;
  localparam int DEBOUNCE    = 2;
  localparam int TXN_CYCLES  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       bridge_start;
  logic       bridge_ready = 1'b1;
  logic [7:0] bridge_joypad = 8'hFF;
  logic       bridge_joypad_valid = 1'b0;
  logic [7:0] buttons, pressed, released;
  logic       update, timeout_err;

  always #5 clk = ~clk;

  joypad_poller #(
    .POLL_PERIOD (POLL_PERIOD),
    .TIMEOUT     (TIMEOUT),
    .DEBOUNCE    (DEBOUNCE),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .bridge_start        (bridge_start),
    .bridge_ready        (bridge_ready),
    .bridge_joypad       (bridge_joypad),
    .bridge_joypad_valid (bridge_joypad_valid),
    .buttons             (buttons),
    .pressed             (pressed),
    .released            (released),
    .update              (update),
    .timeout_err         (timeout_err)
  );

  typedef struct packed {
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic [7:0] released;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] raw_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         hang = 1'b0;
  bit         hung = 1'b0;
  int         busy = 0;
  logic [7:0] cur_raw = 8'hFF;
  int         edges_since_rel = 0;
  int         first_start_edge = -1;
  int         start_count = 0;
  logic       prev_start = 1'b0;
  logic       prev_update = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Bridge model: each start drops ready for a fixed-length transaction, or forever while hang is set.
  always @(posedge clk) begin
    if (bridge_start) begin
      bridge_ready        <= 1'b0;
      bridge_joypad_valid <= 1'b0;
      hung                <= hang;
      busy                <= hang ? 0 : TXN_CYCLES;
      if (raw_q.size() > 0) cur_raw <= raw_q.pop_front();
      else                  cur_raw <= 8'hFF;
    end else if (hung) begin
      if (!hang) begin
        hung         <= 1'b0;
        bridge_ready <= 1'b1;
      end
    end else if (busy == 1) begin
      bridge_ready        <= 1'b1;
      bridge_joypad_valid <= 1'b1;
      bridge_joypad       <= cur_raw;
      busy                <= 0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end
  end

  always @(posedge clk) begin
    if (rst) edges_since_rel <= 0;
    else     edges_since_rel <= edges_since_rel + 1;
  end

  // Monitor: pops the scoreboard on every update and checks pulse shapes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bridge_start) begin
        start_count++;
        check_output("start_width", {31'd0, prev_start}, 32'd0);
        if (first_start_edge < 0) first_start_edge = edges_since_rel;
      end
      if (prev_update)
        check_output("pulse_clear", {15'd0, update, pressed, released}, 32'd0);
      if (update) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_update: got buttons=%0h, expected no update", buttons);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("buttons",  {24'd0, buttons},  {24'd0, e.buttons});
          check_output("pressed",  {24'd0, pressed},  {24'd0, e.pressed});
          check_output("released", {24'd0, released}, {24'd0, e.released});
        end
      end
    end
    prev_start  = bridge_start;
    prev_update = update;
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input logic [7:0] raw, input logic [7:0] eb,
                                input logic [7:0] ep, input logic [7:0] er);
    exp_t e;
    e.buttons  = eb;
    e.pressed  = ep;
    e.released = er;
    raw_q.push_back(raw);
    exp_q.push_back(e);
    wait_drain();
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bridge_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("start_seen", {31'd0, bridge_start}, 32'd1);
  endtask

  initial begin
    int n;
    int sc;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", {6'd0, bridge_start, timeout_err, update, buttons, pressed, released[6:0]}, 32'd0);
    check_output("reset_released", {24'd0, released}, 32'd0);
    rst = 1'b0;

    // Idle pad: first request lands POLL_PERIOD edges after reset release.
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'h00);
    check_output("first_start_edge", first_start_edge, POLL_PERIOD);

    // A held for two polls, then released for two polls.
    apply_stimulus(8'hFE, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'hFE, 8'h01, 8'h01, 8'h00);
    apply_stimulus(8'hFF, 8'h01, 8'h00, 8'h00);
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'h01);

    // Bouncing A never settles.
    apply_stimulus(8'hFE, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'hFE, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'h00);

    // Everything held, then everything released.
    apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'h00, 8'hFF, 8'hFF, 8'h00);
    apply_stimulus(8'hFF, 8'hFF, 8'h00, 8'h00);
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'hFF);

    // Stuck bridge: the flag appears 64 edges after the edge that accepted start.
    hang = 1'b1;
    wait_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 200);
    check_output("timeout_latency", n, TIMEOUT + 1);
    hang = 1'b0;
    apply_stimulus(8'hFF, 8'h00, 8'h00, 8'h00);
    check_output("timeout_clear", {31'd0, timeout_err}, 32'd0);

    // Disable while a poll is in flight: it still completes, then polling stops.
    exp_q.push_back('{8'h00, 8'h00, 8'h00});
    raw_q.push_back(8'hFE);
    wait_start();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_drain();
    sc = start_count;
    repeat (120) @(negedge clk);
    check_output("no_start_disabled", start_count - sc, 0);
    enable = 1'b1;
    apply_stimulus(8'hFE, 8'h01, 8'h01, 8'h00);

    // Reset during a transaction clears every output on the next edge.
    raw_q.push_back(8'hFE);
    wait_start();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_busy_buttons", {24'd0, buttons}, 32'd0);
    check_output("rst_busy_flags", {28'd0, bridge_start, timeout_err, update, |{pressed, released}}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    raw_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
